nsw_bbm_seq: RTL and testbench

- Break-before-make sequencer for a bank of nsw1 NFET pass switches that share one analog node.
- Drives one-hot SW controls so that at most one switch conducts at any time.
- Inserts a programmable dead time, during which all switches are off, before any new switch closes.
- Inserts a settle time after the close before signalling completion to the digital requester.

---
 rtl/rail12_nsw_pkg.sv | 23 ++
 rtl/nsw_dly_cnt.sv | 30 +++
 rtl/nsw_bbm_seq.sv | 138 +++++++++++++
 tb/tb_nsw_bbm_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rail12_nsw_pkg.sv
// Shared types and helpers for the NFET pass-switch break-before-make sequencer.
package rail12_nsw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    SETTLE
  } state_e;

  localparam int unsigned DEAD_CYC_DEF   = 4;
  localparam int unsigned SETTLE_CYC_DEF = 8;
  localparam int          MAX_SW         = 64;

  // Callers narrow the result to their own switch count; out-of-range selects give all-zero.
  function automatic logic [MAX_SW-1:0] onehot(input int sel, input int n_sw);
    logic [MAX_SW-1:0] v;
    for (int i = 0; i < MAX_SW; i++) begin
      v[i] = (i == sel) && (sel < n_sw);
    end
    return v;
  endfunction

endpackage

// File: rtl/nsw_dly_cnt.sv
// Loadable saturating down-counter that times both the dead and the settle phase.
module nsw_dly_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nsw_bbm_seq.sv
// Break-before-make sequencer: opens every switch for a dead time, then closes
// exactly one and waits a settle time before reporting completion.
module nsw_bbm_seq
  import rail12_nsw_pkg::*;
#(
  parameter int N_SW       = 8,
  parameter int SEL_W      = $clog2(N_SW),
  parameter int DEAD_CYC   = DEAD_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REQ,
  input  logic [SEL_W-1:0] SEL,
  input  logic             OFF,
  input  logic             KILL,
  output logic             READY,
  output logic             DONE,
  output logic             ERR,
  output logic [N_SW-1:0]  SW,
  output logic             ACT_VLD,
  output logic [SEL_W-1:0] ACT_SEL
);

  localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_e           state;
  logic [SEL_W-1:0] target;
  logic             make_pend;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             accept;
  logic             sel_bad;
  logic             same_ch;
  logic [N_SW-1:0]  target_oh;

  assign accept    = READY && REQ && !KILL;
  assign sel_bad   = !OFF && (int'(SEL) >= N_SW);
  assign same_ch   = !OFF && ACT_VLD && (SEL == ACT_SEL);
  assign target_oh = N_SW'(onehot(int'(target), N_SW));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state == IDLE && accept && !sel_bad && !same_ch) begin
      cnt_load = 1'b1;
      cnt_val  = DEAD_LD;
    end else if (state == DEAD && cnt_zero && make_pend) begin
      cnt_load = 1'b1;
      cnt_val  = SETTLE_LD;
    end
  end

  nsw_dly_cnt #(
    .CNT_W(CNT_W)
  ) u_dly (
    .clk     (CLK),
    .rst_n   (RSTN),
    .clear   (KILL),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      target    <= '0;
      make_pend <= 1'b0;
      READY     <= 1'b1;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      SW        <= '0;
      ACT_VLD   <= 1'b0;
      ACT_SEL   <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      if (KILL) begin
        // Emergency open drops any in-flight sequence silently.
        state     <= IDLE;
        make_pend <= 1'b0;
        READY     <= 1'b1;
        SW        <= '0;
        ACT_VLD   <= 1'b0;
        ACT_SEL   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              if (sel_bad) begin
                ERR <= 1'b1;
              end else if (same_ch) begin
                DONE <= 1'b1;
              end else begin
                SW        <= '0;
                ACT_VLD   <= 1'b0;
                ACT_SEL   <= '0;
                READY     <= 1'b0;
                target    <= SEL;
                make_pend <= !OFF;
                state     <= DEAD;
              end
            end
          end
          DEAD: begin
            if (cnt_zero) begin
              if (make_pend) begin
                SW      <= target_oh;
                ACT_VLD <= 1'b1;
                ACT_SEL <= target;
                state   <= SETTLE;
              end else begin
                DONE  <= 1'b1;
                READY <= 1'b1;
                state <= IDLE;
              end
            end
          end
          SETTLE: begin
            if (cnt_zero) begin
              DONE      <= 1'b1;
              READY     <= 1'b1;
              make_pend <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nsw_bbm_seq.sv
// Self-checking bench for nsw_bbm_seq: directed scenarios plus random traffic
// compared against an event-timeline reference model.
module tb_nsw_bbm_seq;

  localparam int N_SW   = 8;
  localparam int SEL_W  = 4;
  localparam int DEAD   = 4;
  localparam int SETTLE = 8;

  logic             CLK  = 1'b0;
  logic             RSTN = 1'b0;
  logic             REQ, OFF, KILL;
  logic [SEL_W-1:0] SEL;
  logic             READY, DONE, ERR, ACT_VLD;
  logic [N_SW-1:0]  SW;
  logic [SEL_W-1:0] ACT_SEL;

  int total   = 0;
  int bad     = 0;
  int edge_no = 0;

  // Reference model: switch state plus the absolute edge numbers of the next make and done.
  logic            m_ready, m_done, m_err, m_act_vld, m_busy, m_make;
  logic [N_SW-1:0] m_sw;
  int              m_act_sel, m_target, m_make_edge, m_done_edge;

  nsw_bbm_seq #(
    .N_SW(N_SW), .SEL_W(SEL_W), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .SEL(SEL), .OFF(OFF), .KILL(KILL),
    .READY(READY), .DONE(DONE), .ERR(ERR), .SW(SW), .ACT_VLD(ACT_VLD), .ACT_SEL(ACT_SEL)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    total++;
    if (!$onehot0(SW) || DONE && ERR) begin
      bad++;
      $display("FAIL invariant SW=%b DONE=%b ERR=%b required onehot0 SW and not DONE&ERR", SW, DONE, ERR);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_ready = 1'b1; m_done = 1'b0; m_err = 1'b0; m_act_vld = 1'b0;
    m_busy = 1'b0; m_make = 1'b0; m_sw = '0; m_act_sel = 0; m_target = 0;
    m_make_edge = 0; m_done_edge = 0;
  endtask

  task automatic model_edge();
    if (!RSTN) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (KILL) begin
        m_busy = 1'b0; m_ready = 1'b1; m_sw = '0; m_act_vld = 1'b0; m_act_sel = 0;
      end else if (m_busy) begin
        if (m_make && edge_no == m_make_edge) begin
          m_sw = N_SW'(1) << m_target; m_act_vld = 1'b1; m_act_sel = m_target;
        end
        if (edge_no == m_done_edge) begin
          m_done = 1'b1; m_ready = 1'b1; m_busy = 1'b0;
        end
      end else if (REQ) begin
        if (!OFF && int'(SEL) >= N_SW) begin
          m_err = 1'b1;
        end else if (!OFF && m_act_vld && int'(SEL) == m_act_sel) begin
          m_done = 1'b1;
        end else begin
          m_sw = '0; m_act_vld = 1'b0; m_act_sel = 0; m_busy = 1'b1; m_ready = 1'b0;
          m_make = !OFF; m_target = int'(SEL);
          m_make_edge = edge_no + DEAD;
          m_done_edge = edge_no + DEAD + (OFF ? 0 : SETTLE);
        end
      end
    end
  endtask

  task automatic set_in(input logic r, input logic [SEL_W-1:0] s, input logic o, input logic k);
    REQ = r; SEL = s; OFF = o; KILL = k;
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_no++;
    model_edge();
    #1;
  endtask

  // Issues a request and waits (bounded) for its DONE; returns edges from accept to DONE.
  task automatic run_seq(input logic [SEL_W-1:0] s, output int cyc);
    set_in(1'b1, s, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick(); tick();
    total++; if (READY !== 1'b1)   begin bad++; $display("FAIL reset_ready got=%b want=1", READY); end
    total++; if (SW !== 8'h00)     begin bad++; $display("FAIL reset_sw got=%h want=00", SW); end
    total++; if (DONE !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", DONE); end
    total++; if (ERR !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b want=0", ERR); end
    total++; if (ACT_VLD !== 1'b0) begin bad++; $display("FAIL reset_act_vld got=%b want=0", ACT_VLD); end
    total++; if (ACT_SEL !== 4'd0) begin bad++; $display("FAIL reset_act_sel got=%0d want=0", ACT_SEL); end
    #2 RSTN = 1'b1;
  endtask

  task automatic test_make();
    logic [N_SW-1:0] exp_sw;
    set_in(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total++; if (READY !== 1'b0) begin bad++; $display("FAIL make_ready_drop got=%b want=0", READY); end
    total++; if (SW !== 8'h00)   begin bad++; $display("FAIL make_sw_k got=%h want=00", SW); end
    for (int i = 1; i <= DEAD + SETTLE; i++) begin
      tick();
      exp_sw = (i >= DEAD) ? 8'h08 : 8'h00;
      total++; if (SW !== exp_sw) begin bad++; $display("FAIL make_sw edge %0d got=%h want=%h", i, SW, exp_sw); end
      total++; if (DONE !== (i == DEAD + SETTLE)) begin
        bad++; $display("FAIL make_done edge %0d got=%b want=%b", i, DONE, (i == DEAD + SETTLE));
      end
    end
    total++; if (ACT_SEL !== 4'd3) begin bad++; $display("FAIL make_act_sel got=%0d want=3", ACT_SEL); end
    total++; if (ACT_VLD !== 1'b1) begin bad++; $display("FAIL make_act_vld got=%b want=1", ACT_VLD); end
    total++; if (READY !== 1'b1)   begin bad++; $display("FAIL make_ready got=%b want=1", READY); end
    tick();
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL make_done_pulse got=%b want=0", DONE); end
  endtask

  task automatic test_break();
    int zero_cnt, cyc;
    total++; if (SW !== 8'h08) begin bad++; $display("FAIL break_pre_sw got=%h want=08", SW); end
    set_in(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    zero_cnt = 0;
    cyc = 0;
    while (SW === 8'h00 && zero_cnt < 20) begin
      zero_cnt++;
      tick();
      cyc++;
    end
    total++; if (zero_cnt != DEAD) begin bad++; $display("FAIL break_dead_len got=%0d want=%0d", zero_cnt, DEAD); end
    total++; if (SW !== 8'h20)     begin bad++; $display("FAIL break_new_sw got=%h want=20", SW); end
    while (DONE !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    total++; if (cyc != DEAD + SETTLE) begin
      bad++; $display("FAIL break_done_time got=%0d want=%0d", cyc, DEAD + SETTLE);
    end
  endtask

  task automatic test_same_and_err();
    logic [SEL_W-1:0] bad_sel;
    set_in(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total++; if (DONE !== 1'b1)  begin bad++; $display("FAIL same_done got=%b want=1", DONE); end
    total++; if (READY !== 1'b1) begin bad++; $display("FAIL same_ready got=%b want=1", READY); end
    total++; if (SW !== 8'h20)   begin bad++; $display("FAIL same_sw got=%h want=20", SW); end
    tick();
    total++; if (DONE !== 1'b0 || READY !== 1'b1) begin
      bad++; $display("FAIL same_after got done=%b ready=%b want done=0 ready=1", DONE, READY);
    end
    for (int i = 0; i < 3; i++) begin
      bad_sel = (i == 0) ? 4'd9 : SEL_W'($urandom_range(8, 15));
      set_in(1'b1, bad_sel, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      total++; if (ERR !== 1'b1 || DONE !== 1'b0) begin
        bad++; $display("FAIL err_pulse sel=%0d got err=%b done=%b want err=1 done=0", bad_sel, ERR, DONE);
      end
      total++; if (SW !== 8'h20 || READY !== 1'b1) begin
        bad++; $display("FAIL err_hold got sw=%h ready=%b want sw=20 ready=1", SW, READY);
      end
      tick();
      total++; if (ERR !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", ERR); end
    end
  endtask

  task automatic test_off();
    int cyc;
    run_seq(4'd2, cyc);
    total++; if (SW !== 8'h04 || cyc != DEAD + SETTLE) begin
      bad++; $display("FAIL off_setup got sw=%h cyc=%0d want sw=04 cyc=%0d", SW, cyc, DEAD + SETTLE);
    end
    set_in(1'b1, 4'd6, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total++; if (SW !== 8'h00 || ACT_VLD !== 1'b0 || READY !== 1'b0) begin
      bad++; $display("FAIL off_break got sw=%h vld=%b ready=%b want 00 0 0", SW, ACT_VLD, READY);
    end
    for (int i = 1; i <= DEAD; i++) begin
      tick();
      total++; if (DONE !== (i == DEAD) || SW !== 8'h00) begin
        bad++; $display("FAIL off_seq edge %0d got done=%b sw=%h want done=%b sw=00", i, DONE, SW, (i == DEAD));
      end
    end
    total++; if (READY !== 1'b1 || ACT_VLD !== 1'b0 || ACT_SEL !== 4'd0) begin
      bad++; $display("FAIL off_end got ready=%b vld=%b sel=%0d want 1 0 0", READY, ACT_VLD, ACT_SEL);
    end
  endtask

  task automatic test_kill();
    int done_seen;
    set_in(1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (DEAD + 2) tick();
    total++; if (SW !== 8'h02) begin bad++; $display("FAIL kill_pre_sw got=%h want=02", SW); end
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total++; if (SW !== 8'h00 || READY !== 1'b1 || DONE !== 1'b0) begin
      bad++; $display("FAIL kill_open got sw=%h ready=%b done=%b want 00 1 0", SW, READY, DONE);
    end
    total++; if (ACT_VLD !== 1'b0 || ACT_SEL !== 4'd0) begin
      bad++; $display("FAIL kill_act got vld=%b sel=%0d want 0 0", ACT_VLD, ACT_SEL);
    end
    done_seen = 0;
    repeat (SETTLE + 4) begin
      tick();
      if (DONE === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL kill_no_done got=%0d want=0", done_seen); end
    set_in(1'b1, 4'd4, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total++; if (READY !== 1'b1 || SW !== 8'h00) begin
      bad++; $display("FAIL kill_req_same_edge got ready=%b sw=%h want 1 00", READY, SW);
    end
    repeat (DEAD + 1) tick();
    total++; if (SW !== 8'h00 || ACT_VLD !== 1'b0) begin
      bad++; $display("FAIL kill_req_discard got sw=%h vld=%b want 00 0", SW, ACT_VLD);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    run_seq(4'd6, cyc);
    set_in(1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick(); tick();
    #2 RSTN = 1'b0;
    model_reset();
    #1;
    total++; if (READY !== 1'b1 || SW !== 8'h00 || DONE !== 1'b0 || ERR !== 1'b0) begin
      bad++; $display("FAIL rst_dead got ready=%b sw=%h done=%b err=%b want 1 00 0 0", READY, SW, DONE, ERR);
    end
    #2 RSTN = 1'b1;
    set_in(1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (DEAD + 1) tick();
    #2 RSTN = 1'b0;
    model_reset();
    #1;
    total++; if (SW !== 8'h00 || ACT_VLD !== 1'b0 || ACT_SEL !== 4'd0 || READY !== 1'b1) begin
      bad++; $display("FAIL rst_settle got sw=%h vld=%b sel=%0d ready=%b want 00 0 0 1", SW, ACT_VLD, ACT_SEL, READY);
    end
    #2 RSTN = 1'b1;
    run_seq(4'd7, cyc);
    total++; if (cyc != DEAD + SETTLE || SW !== 8'h80 || ACT_SEL !== 4'd7) begin
      bad++; $display("FAIL rst_after got cyc=%0d sw=%h sel=%0d want %0d 80 7", cyc, SW, ACT_SEL, DEAD + SETTLE);
    end
  endtask

  task automatic test_random();
    logic [SEL_W-1:0] s;
    for (int n = 0; n < 800; n++) begin
      s = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom_range(8, 15)) : SEL_W'($urandom_range(0, 7));
      set_in($urandom_range(0, 2) == 0, s, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
      tick();
      total++; if (SW !== m_sw) begin
        bad++; if (bad < 40) $display("FAIL rnd_sw edge %0d got=%h want=%h", edge_no, SW, m_sw);
      end
      total++; if (READY !== m_ready) begin
        bad++; if (bad < 40) $display("FAIL rnd_ready edge %0d got=%b want=%b", edge_no, READY, m_ready);
      end
      total++; if (DONE !== m_done) begin
        bad++; if (bad < 40) $display("FAIL rnd_done edge %0d got=%b want=%b", edge_no, DONE, m_done);
      end
      total++; if (ERR !== m_err) begin
        bad++; if (bad < 40) $display("FAIL rnd_err edge %0d got=%b want=%b", edge_no, ERR, m_err);
      end
      total++; if (ACT_VLD !== m_act_vld || ACT_SEL !== SEL_W'(m_act_sel)) begin
        bad++; if (bad < 40) $display("FAIL rnd_act edge %0d got=%b/%0d want=%b/%0d", edge_no, ACT_VLD, ACT_SEL, m_act_vld, m_act_sel);
      end
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    set_in(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_make();
    test_break();
    test_same_and_err();
    test_off();
    test_kill();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
